nibble_serial_adder_ctrl: RTL

//  Sequencer that adds two WIDTH-bit operands using one shared 4-bit ripple adder slice
//  (the half/full adder chain), processing one nibble per clock, LSB nibble first.
//  A registered carry links successive nibbles.

---
 rtl/nibble_serial_adder_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a shared 4-bit ripple slice.
// done pulses NIB edges after the accepting edge; start is ignored while busy.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic [3:0]       slice_sum;
  logic             slice_co;
  logic             rc;
  logic [WIDTH+3:0] sum_cat;
  logic [WIDTH-1:0] sum_shift;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(NIB - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ripple slice: full adder chain over the low nibble of the operand shift registers.
  always_comb begin
    slice_sum = '0;
    rc        = carry;
    for (int i = 0; i < 4; i++) begin
      slice_sum[i] = a_sh[i] ^ b_sh[i] ^ rc;
      rc           = (a_sh[i] & b_sh[i]) | (rc & (a_sh[i] ^ b_sh[i]));
    end
    slice_co = rc;
  end

  // New nibble enters from the MSB side; the concatenation keeps WIDTH=4 legal.
  always_comb begin
    sum_cat   = {slice_sum, sum} >> 4;
    sum_shift = sum_cat[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum   <= sum_shift;
      carry <= slice_co;
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout <= slice_co;
        // On the last pass bit 3 of the shift registers is the original operand MSB.
        ovf  <= (a_sh[3] == b_sh[3]) && (slice_sum[3] != a_sh[3]);
      end
    end
  end

endmodule
